// File: rtl/mimo_frame_serializer.sv
// mimo_frame_serializer: streams one 4x4 MIMO channel frame as 42 words over a free-running 14-cycle slot on three lanes
//
// Optional feature macro: SER_FRAME_CNT_EN adds frame_cnt_o, a wrapping count of real frames loaded.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   frame_valid        upstream frame present
//   frame_ready        serializer can accept a frame this cycle
//   h_re_i, h_im_i     Re/Im H(i,j) at word index 4*i+j, IN_WL bits each
//   y_i                received words y[0..7], word m at [m*IN_WL +: IN_WL]
//   In0, In1, In2      lane words for the current slot cycle
//   tx_active          current slot carries a real frame
//   slot_start         high during slot cycle 0
//   frame_cnt_o        (SER_FRAME_CNT_EN only) count of real frames loaded
module mimo_frame_serializer #(
    parameter int IN_WL = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    input  logic [16*IN_WL-1:0]   h_re_i,
    input  logic [16*IN_WL-1:0]   h_im_i,
    input  logic [8*IN_WL-1:0]    y_i,
    output logic [IN_WL-1:0]      In0,
    output logic [IN_WL-1:0]      In1,
    output logic [IN_WL-1:0]      In2,
    output logic                  tx_active,
`ifdef SER_FRAME_CNT_EN
    output logic [7:0]            frame_cnt_o,
`endif
    output logic                  slot_start
);
    localparam int FW = 42 * IN_WL;

    logic [3:0]    slot_cnt;
    logic          pend_full;
    logic [FW-1:0] pend;
    logic [FW-1:0] act;
    logic [FW-1:0] w_in;
    logic          boundary;
    logic          hs;

    // Word k of the frame vector lives at bits [k*IN_WL +: IN_WL].
    always_comb begin
        w_in = '0;
        for (int m = 0; m < 8; m++)
            w_in[(2+m)*IN_WL +: IN_WL] = y_i[m*IN_WL +: IN_WL];
        for (int k = 0; k < 16; k++) begin
            w_in[(10+2*k)*IN_WL +: IN_WL] = h_im_i[k*IN_WL +: IN_WL];
            w_in[(11+2*k)*IN_WL +: IN_WL] = h_re_i[k*IN_WL +: IN_WL];
        end
    end

    assign boundary    = slot_cnt == 4'd13;
    assign frame_ready = ~pend_full & ~rst;
    assign hs          = frame_valid & frame_ready;
    assign slot_start  = slot_cnt == 4'd0;

    // The highest three words go out first; shifting up by three words brings the next group into view.
    assign In0 = act[39*IN_WL +: IN_WL];
    assign In1 = act[40*IN_WL +: IN_WL];
    assign In2 = act[41*IN_WL +: IN_WL];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt  <= 4'd13;
            pend_full <= 1'b0;
            pend      <= '0;
            act       <= '0;
            tx_active <= 1'b0;
        end else begin
            slot_cnt  <= boundary ? 4'd0 : slot_cnt + 4'd1;
            // A handshake is only possible with pending empty, so it always wins over the boundary clear.
            pend_full <= hs | (pend_full & ~boundary);
            if (hs)
                pend <= w_in;
            if (boundary) begin
                act       <= pend_full ? pend : '0;
                tx_active <= pend_full;
            end else begin
                act <= act << (3*IN_WL);
            end
        end
    end

`ifdef SER_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_cnt_o <= 8'd0;
        else if (boundary && pend_full)
            frame_cnt_o <= frame_cnt_o + 8'd1;
    end
`endif
endmodule

// File: tb/tb_mimo_frame_serializer.sv
// tb_mimo_frame_serializer: directed self-checking bench for mimo_frame_serializer
module tb_mimo_frame_serializer;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_valid = 1'b0;
    logic          frame_ready;
    logic [255:0]  h_re_i = '0;
    logic [255:0]  h_im_i = '0;
    logic [127:0]  y_i = '0;
    logic [15:0]   In0, In1, In2;
    logic          tx_active, slot_start;
`ifdef SER_FRAME_CNT_EN
    logic [7:0]    frame_cnt_o;
`endif
    logic [15:0]   lane [3];
    logic [3:0]    tb_t;
    int            nvec = 0;
    int            nerr = 0;

    mimo_frame_serializer #(.IN_WL(16)) dut (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .h_re_i(h_re_i), .h_im_i(h_im_i), .y_i(y_i),
        .In0(In0), .In1(In1), .In2(In2), .tx_active(tx_active),
`ifdef SER_FRAME_CNT_EN
        .frame_cnt_o(frame_cnt_o),
`endif
        .slot_start(slot_start)
    );

    always #5 clk = ~clk;

    always_comb begin
        lane[0] = In0;
        lane[1] = In1;
        lane[2] = In2;
    end

    // Expected slot position: 13 in reset, first edge after release starts cycle 0.
    always @(posedge clk or posedge rst)
        if (rst) tb_t <= 4'd13;
        else     tb_t <= (tb_t == 4'd13) ? 4'd0 : tb_t + 4'd1;

    function automatic logic [15:0] hval(int s, int i, int j);
        return 16'(16*i + j + 1 + 300*s);
    endfunction

    // Expected frame word W[k] for frame pattern s.
    function automatic logic [15:0] wexp(int s, int k);
        int idx;
        logic [15:0] re;
        if (k < 2) return 16'd0;
        if (k < 10) return 16'(100 + (k-2) + 300*s);
        idx = k - 10;
        re = hval(s, idx/8, (idx%8)/2);
        return (idx % 2) ? re : -re;
    endfunction

    task automatic set_frame(input int s);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                h_re_i[(4*i+j)*16 +: 16] = hval(s, i, j);
                h_im_i[(4*i+j)*16 +: 16] = -hval(s, i, j);
            end
        for (int m = 0; m < 8; m++)
            y_i[m*16 +: 16] = 16'(100 + m + 300*s);
    endtask

    task automatic wait_t(input int v);
        int n = 0;
        @(negedge clk);
        while (tb_t != 4'(v) && n < 20) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (tb_t != 4'(v)) begin
            nerr++;
            $display("FAIL wait_t slot cycle got %0d exp %0d", tb_t, v);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({In0, In1, In2, tx_active, slot_start, frame_ready} !== 51'd0) begin
            nerr++;
            $display("FAIL reset_outputs got %h exp 0", {In0, In1, In2, tx_active, slot_start, frame_ready});
        end
`ifdef SER_FRAME_CNT_EN
        nvec++;
        if (frame_cnt_o !== 8'd0) begin
            nerr++;
            $display("FAIL reset_cnt got %0d exp 0", frame_cnt_o);
        end
`endif
        rst = 1'b0;
        #1;
        nvec++;
        if (frame_ready !== 1'b1) begin
            nerr++;
            $display("FAIL ready_after_release got %b exp 1", frame_ready);
        end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            nvec++;
            if (slot_start !== (c % 14 == 0) || tx_active !== 1'b0 || {In0, In1, In2} !== 48'd0) begin
                nerr++;
                $display("FAIL idle c=%0d got ss=%b act=%b lanes=%h exp ss=%b act=0 lanes=0",
                         c, slot_start, tx_active, {In0, In1, In2}, c % 14 == 0);
            end
        end
    endtask

    task automatic test_single();
        wait_t(0);
        set_frame(0);
        frame_valid = 1'b1;
        nvec++;
        if (frame_ready !== 1'b1) begin
            nerr++;
            $display("FAIL single_ready got %b exp 1", frame_ready);
        end
        @(negedge clk);
        frame_valid = 1'b0;
        nvec++;
        if (frame_ready !== 1'b0 || tx_active !== 1'b0) begin
            nerr++;
            $display("FAIL single_pending got ready=%b act=%b exp ready=0 act=0", frame_ready, tx_active);
        end
        wait_t(0);
        for (int t = 0; t < 14; t++) begin
            nvec++;
            if (tx_active !== 1'b1 || slot_start !== (t == 0)) begin
                nerr++;
                $display("FAIL single_flags t=%0d got act=%b ss=%b exp act=1 ss=%b", t, tx_active, slot_start, t == 0);
            end
            for (int l = 0; l < 3; l++) begin
                nvec++;
                if (lane[l] !== wexp(0, 3*(13-t)+l)) begin
                    nerr++;
                    $display("FAIL single t=%0d lane%0d got %h exp %h", t, l, lane[l], wexp(0, 3*(13-t)+l));
                end
            end
            @(negedge clk);
        end
        nvec++;
        if (tx_active !== 1'b0 || {In0, In1, In2} !== 48'd0) begin
            nerr++;
            $display("FAIL single_after got act=%b lanes=%h exp 0", tx_active, {In0, In1, In2});
        end
    endtask

    task automatic test_back_to_back();
        wait_t(0);
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 14; t++) begin
                if (k > 0) begin
                    nvec++;
                    if (tx_active !== 1'b1) begin
                        nerr++;
                        $display("FAIL b2b_active k=%0d t=%0d got %b exp 1", k, t, tx_active);
                    end
                    for (int l = 0; l < 3; l++) begin
                        nvec++;
                        if (lane[l] !== wexp(k, 3*(13-t)+l)) begin
                            nerr++;
                            $display("FAIL b2b k=%0d t=%0d lane%0d got %h exp %h", k, t, l, lane[l], wexp(k, 3*(13-t)+l));
                        end
                    end
                end
                if (t == 0) begin
                    nvec++;
                    if (frame_ready !== 1'b1) begin
                        nerr++;
                        $display("FAIL b2b_ready0 k=%0d got %b exp 1", k, frame_ready);
                    end
                    if (k < 3) begin
                        set_frame(k+1);
                        frame_valid = 1'b1;
                    end else
                        frame_valid = 1'b0;
                end
                if (t == 1) begin
                    nvec++;
                    if (frame_ready !== (k == 3)) begin
                        nerr++;
                        $display("FAIL b2b_ready1 k=%0d got %b exp %b", k, frame_ready, k == 3);
                    end
                end
                @(negedge clk);
            end
        end
        frame_valid = 1'b0;
    endtask

    task automatic test_late();
        wait_t(13);
        nvec++;
        if (frame_ready !== 1'b1) begin
            nerr++;
            $display("FAIL late_ready got %b exp 1", frame_ready);
        end
        set_frame(5);
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        nvec++;
        if (frame_ready !== 1'b0) begin
            nerr++;
            $display("FAIL late_pending got %b exp 0", frame_ready);
        end
        for (int t = 0; t < 14; t++) begin
            nvec++;
            if (tx_active !== 1'b0 || {In0, In1, In2} !== 48'd0) begin
                nerr++;
                $display("FAIL late_idle t=%0d got act=%b lanes=%h exp 0", t, tx_active, {In0, In1, In2});
            end
            @(negedge clk);
        end
        for (int t = 0; t < 14; t++) begin
            nvec++;
            if (tx_active !== 1'b1) begin
                nerr++;
                $display("FAIL late_active t=%0d got %b exp 1", t, tx_active);
            end
            for (int l = 0; l < 3; l++) begin
                nvec++;
                if (lane[l] !== wexp(5, 3*(13-t)+l)) begin
                    nerr++;
                    $display("FAIL late t=%0d lane%0d got %h exp %h", t, l, lane[l], wexp(5, 3*(13-t)+l));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        wait_t(0);
        set_frame(6);
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        wait_t(0);
        for (int t = 0; t < 7; t++) begin
            for (int l = 0; l < 3; l++) begin
                nvec++;
                if (lane[l] !== wexp(6, 3*(13-t)+l)) begin
                    nerr++;
                    $display("FAIL midrst_pre t=%0d lane%0d got %h exp %h", t, l, lane[l], wexp(6, 3*(13-t)+l));
                end
            end
            if (t == 0) begin
                set_frame(7);
                frame_valid = 1'b1;
            end
            if (t == 1) frame_valid = 1'b0;
            if (t < 6) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        nvec++;
        if ({In0, In1, In2, tx_active, slot_start, frame_ready} !== 51'd0) begin
            nerr++;
            $display("FAIL midrst_async got %h exp 0", {In0, In1, In2, tx_active, slot_start, frame_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if (frame_ready !== 1'b1) begin
            nerr++;
            $display("FAIL midrst_ready got %b exp 1", frame_ready);
        end
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            nvec++;
            if (slot_start !== (c % 14 == 0) || tx_active !== 1'b0 || {In0, In1, In2} !== 48'd0) begin
                nerr++;
                $display("FAIL midrst_idle c=%0d got ss=%b act=%b lanes=%h exp ss=%b act=0 lanes=0",
                         c, slot_start, tx_active, {In0, In1, In2}, c % 14 == 0);
            end
        end
    endtask

`ifdef SER_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int n = 0;
        nvec++;
        if (frame_cnt_o !== 8'd0) begin
            nerr++;
            $display("FAIL cnt_start got %0d exp 0", frame_cnt_o);
        end
        wait_t(0);
        set_frame(2);
        frame_valid = 1'b1;
        for (int c = 0; c < 257*14 + 50 && n < 257; c++) begin
            if (frame_ready) n++;
            @(negedge clk);
        end
        frame_valid = 1'b0;
        repeat (30) @(negedge clk);
        nvec++;
        if (n != 257 || frame_cnt_o !== 8'd1) begin
            nerr++;
            $display("FAIL cnt_wrap got %0d after %0d accepts exp 1 after 257", frame_cnt_o, n);
        end
    endtask
`endif

    initial begin
        set_frame(0);
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_late();
        test_mid_reset();
`ifdef SER_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
